alu_iterative: RTL and testbench

- Execute-stage ALU that consumes the 4-bit operation code produced by the ALU control decoder, plus the two operands.
- Single-cycle ops (AND/OR/ADD/SUB/SLL/SRL/SLT) return a registered result one cycle after acceptance.
- MUL runs as a radix-2 shift-add iterative multiplier over DATA_W cycles.
- A valid/ready handshake on both sides lets the pipeline hazard logic stall fetch/decode while a multiply is in flight.

---
 rtl/alu_iterative.sv | 166 ++++++++++++++++
 tb/tb_alu_iterative.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// Execute-stage ALU with single-cycle logic/arith/shift/compare ops and an
// iterative radix-2 shift-add multiplier.
// Latency: 1 cycle accept->out_valid for single-cycle ops; DATA_W+1 for MUL.
// Backpressure: result held in RESP until out_ready; in_ready low outside IDLE.
//
// Ports:
//   clk, arst            clock (rising edge) and async active-high reset
//   flush                synchronous abort of any in-flight operation
//   in_valid/in_ready    operation handshake (alu_ctrl, alu_in_0, alu_in_1)
//   out_valid/out_ready  result handshake (alu_out, zero_flag)
//   busy                 high while a multiply is iterating (pipeline stall)
module alu_iterative #(
  parameter int DATA_W  = 64,
  parameter int SHAMT_W = 6
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_in_0,
  input  logic [DATA_W-1:0] alu_in_1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero_flag,
  output logic              busy
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  // Iteration index of the final multiply step.
  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   mplier;
  logic [DATA_W-1:0]   acc;
  logic [SHAMT_W-1:0]  cnt;

  logic [DATA_W-1:0]   single_res;
  logic [DATA_W-1:0]   acc_next;
  logic                accept;
  logic                last_iter;

  // Single-cycle result; undefined opcodes fall through to zero.
  always_comb begin
    single_res = '0;
    case (alu_ctrl)
      OP_AND: single_res = alu_in_0 & alu_in_1;
      OP_OR:  single_res = alu_in_0 | alu_in_1;
      OP_ADD: single_res = alu_in_0 + alu_in_1;
      OP_SUB: single_res = alu_in_0 - alu_in_1;
      OP_SLL: single_res = alu_in_0 << alu_in_1[SHAMT_W-1:0];
      OP_SRL: single_res = alu_in_0 >> alu_in_1[SHAMT_W-1:0];
      OP_SLT: single_res = {{(DATA_W-1){1'b0}},
                            ($signed(alu_in_0) < $signed(alu_in_1))};
      default: single_res = '0;
    endcase
  end

  // One shift-add step: add the multiplicand when the current multiplier LSB is set.
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;
  assign last_iter = (cnt == CNT_LAST);

  // A flush in the same cycle as in_valid blocks the accept.
  assign accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = (alu_ctrl == OP_MUL) ? MUL_RUN : RESP;
        end
      end
      MUL_RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = RESP;
        end
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      alu_out   <= '0;
      zero_flag <= 1'b1;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else if (flush) begin
      // Abort: drop the iteration count; alu_out keeps its last value.
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (alu_ctrl == OP_MUL) begin
              mcand  <= alu_in_0;
              mplier <= alu_in_1;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              alu_out   <= single_res;
              zero_flag <= (single_res == '0);
            end
          end
        end
        MUL_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // Wraps back to zero after the final step, ready for the next multiply.
          cnt    <= cnt + SHAMT_W'(1);
          if (last_iter) begin
            alu_out   <= acc_next;
            zero_flag <= (acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
module tb_alu_iterative;

  localparam int DATA_W  = 64;
  localparam int SHAMT_W = 6;
  localparam int MAXLAT  = 200;

  logic              clk;
  logic              arst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_in_0;
  logic [DATA_W-1:0] alu_in_1;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_out;
  logic              zero_flag;
  logic              busy;

  int pass_cnt;
  int total_cnt;

  alu_iterative #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .arst      (arst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .alu_in_0  (alu_in_0),
    .alu_in_1  (alu_in_1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .zero_flag (zero_flag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation from IDLE, waits (bounded) for the result, then
  // retires it with a one-cycle out_ready pulse. lat counts edges from the
  // accept edge inclusive, so a single-cycle op reports 1.
  task automatic run_op(input logic [3:0] ctrl, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, output int lat,
                        output logic [DATA_W-1:0] res, output logic zf);
    alu_ctrl = ctrl; alu_in_0 = a; alu_in_1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < MAXLAT) begin
      @(posedge clk); #1;
      lat++;
    end
    res = alu_out;
    zf  = zero_flag;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = 4'd0; alu_in_0 = '0; alu_in_1 = '0;
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({in_ready, out_valid, busy, zero_flag} !== 4'b1001 || alu_out !== '0)
      $display("FAIL reset: rdy/vld/busy/zf=%b%b%b%b out=%h, want 1001 out=0",
               in_ready, out_valid, busy, zero_flag, alu_out);
    else pass_cnt++;
  endtask

  task automatic test_add_sub();
    int lat; logic [DATA_W-1:0] res; logic zf;
    run_op(4'd2, 64'd5, 64'd7, lat, res, zf);
    total_cnt++;
    if (lat !== 1 || res !== 64'd12 || zf !== 1'b0)
      $display("FAIL add: lat=%0d res=%h zf=%b, want lat=1 res=c zf=0", lat, res, zf);
    else pass_cnt++;
    run_op(4'd6, 64'd7, 64'd7, lat, res, zf);
    total_cnt++;
    if (lat !== 1 || res !== 64'd0 || zf !== 1'b1)
      $display("FAIL sub: lat=%0d res=%h zf=%b, want lat=1 res=0 zf=1", lat, res, zf);
    else pass_cnt++;
    run_op(4'd6, 64'd0, 64'd1, lat, res, zf);
    total_cnt++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF || zf !== 1'b0)
      $display("FAIL sub_wrap: res=%h zf=%b, want ffffffffffffffff zf=0", res, zf);
    else pass_cnt++;
    run_op(4'd0, 64'hF0F0, 64'h0FF0, lat, res, zf);
    total_cnt++;
    if (res !== 64'h00F0) $display("FAIL and: res=%h, want f0", res);
    else pass_cnt++;
    run_op(4'd1, 64'hF000, 64'h000F, lat, res, zf);
    total_cnt++;
    if (res !== 64'hF00F) $display("FAIL or: res=%h, want f00f", res);
    else pass_cnt++;
  endtask

  task automatic test_slt_shift();
    int lat; logic [DATA_W-1:0] res; logic zf;
    run_op(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat, res, zf);
    total_cnt++;
    if (res !== 64'd1 || zf !== 1'b0) $display("FAIL slt_neg: res=%h zf=%b, want 1 zf=0", res, zf);
    else pass_cnt++;
    run_op(4'd7, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, lat, res, zf);
    total_cnt++;
    if (res !== 64'd0 || zf !== 1'b1) $display("FAIL slt_pos: res=%h zf=%b, want 0 zf=1", res, zf);
    else pass_cnt++;
    run_op(4'd4, 64'h8000_0000_0000_0000, 64'd63, lat, res, zf);
    total_cnt++;
    if (res !== 64'd1) $display("FAIL srl: res=%h, want 1", res);
    else pass_cnt++;
    run_op(4'd3, 64'd1, 64'h41, lat, res, zf);
    total_cnt++;
    if (res !== 64'd2) $display("FAIL sll_shamt: res=%h, want 2", res);
    else pass_cnt++;
  endtask

  task automatic test_undefined();
    int lat; logic [DATA_W-1:0] res; logic zf;
    run_op(4'd5, 64'd3, 64'd4, lat, res, zf);
    total_cnt++;
    if (lat !== 1 || res !== 64'd0 || zf !== 1'b1)
      $display("FAIL undef5: lat=%0d res=%h zf=%b, want lat=1 res=0 zf=1", lat, res, zf);
    else pass_cnt++;
    run_op(4'd15, 64'd9, 64'd9, lat, res, zf);
    total_cnt++;
    if (lat !== 1 || res !== 64'd0 || zf !== 1'b1)
      $display("FAIL undef15: lat=%0d res=%h zf=%b, want lat=1 res=0 zf=1", lat, res, zf);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    int lat; int busy_cycles; logic [DATA_W-1:0] res; logic zf;
    alu_ctrl = 4'd8; alu_in_0 = 64'h1234; alu_in_1 = 64'h10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy_cycles = 0;
    while (!out_valid && lat < MAXLAT) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++;
    if (lat !== 65 || alu_out !== 64'h12340 || zero_flag !== 1'b0)
      $display("FAIL mul_lat: lat=%0d res=%h zf=%b, want lat=65 res=12340 zf=0",
               lat, alu_out, zero_flag);
    else pass_cnt++;
    total_cnt++;
    if (busy_cycles !== 64 || busy !== 1'b0)
      $display("FAIL mul_busy: busy_cycles=%0d busy_in_resp=%b, want 64 and 0",
               busy_cycles, busy);
    else pass_cnt++;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    run_op(4'd8, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, lat, res, zf);
    total_cnt++;
    if (lat !== 65 || res !== 64'hFFFF_FFFF_FFFF_FFF4)
      $display("FAIL mul_neg: lat=%0d res=%h, want lat=65 res=fffffffffffffff4", lat, res);
    else pass_cnt++;
    run_op(4'd8, 64'd0, 64'h1234, lat, res, zf);
    total_cnt++;
    if (res !== 64'd0 || zf !== 1'b1)
      $display("FAIL mul_zero: res=%h zf=%b, want 0 zf=1", res, zf);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int bad;
    alu_ctrl = 4'd2; alu_in_0 = 64'd1; alu_in_1 = 64'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_out !== 64'd3) bad++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (bad != 0 || out_valid !== 1'b1 || alu_out !== 64'd3)
      $display("FAIL backpressure_hold: bad_cycles=%0d out_valid=%b out=%h, want 0, 1, 3",
               bad, out_valid, alu_out);
    else pass_cnt++;
    // Retire and present the next op in the same cycle: it must not be taken yet.
    out_ready = 1'b1; in_valid = 1'b1;
    alu_ctrl = 4'd6; alu_in_0 = 64'd10; alu_in_1 = 64'd4;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0",
               in_ready, out_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || alu_out !== 64'd6)
      $display("FAIL backpressure_next: out_valid=%b out=%h, want 1 6", out_valid, alu_out);
    else pass_cnt++;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_operand_change();
    int lat;
    alu_ctrl = 4'd8; alu_in_0 = 64'd6; alu_in_1 = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_ctrl = 4'd2; alu_in_0 = 64'hDEAD; alu_in_1 = 64'hBEEF;
    lat = 1;
    while (!out_valid && lat < MAXLAT) begin
      if (lat == 10) begin alu_in_0 = '1; alu_in_1 = '1; end
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++;
    if (lat !== 65 || alu_out !== 64'd42)
      $display("FAIL operand_change: lat=%0d res=%h, want lat=65 res=2a", lat, alu_out);
    else pass_cnt++;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_flush_mul();
    int seen; int lat; logic [DATA_W-1:0] res; logic zf;
    alu_ctrl = 4'd8; alu_in_0 = 64'd3; alu_in_1 = 64'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || alu_out !== 64'd42)
      $display("FAIL flush_mul: busy=%b in_ready=%b out_valid=%b out=%h, want 0 1 0 2a",
               busy, in_ready, out_valid, alu_out);
    else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL flush_no_result: out_valid cycles=%0d, want 0", seen);
    else pass_cnt++;
    run_op(4'd2, 64'd10, 64'd20, lat, res, zf);
    total_cnt++;
    if (lat !== 1 || res !== 64'd30)
      $display("FAIL flush_then_add: lat=%0d res=%h, want lat=1 res=1e", lat, res);
    else pass_cnt++;
  endtask

  task automatic test_flush_idle();
    int seen;
    alu_ctrl = 4'd2; alu_in_0 = 64'd1; alu_in_1 = 64'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid || !in_ready) seen++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (seen != 0 || alu_out !== 64'd30)
      $display("FAIL flush_idle: non_idle_cycles=%0d out=%h, want 0 1e", seen, alu_out);
    else pass_cnt++;
    // Flush while a result waits in RESP drops it.
    alu_ctrl = 4'd2; alu_in_0 = 64'd2; alu_in_1 = 64'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_out !== 64'd4)
      $display("FAIL flush_resp: out_valid=%b in_ready=%b out=%h, want 0 1 4",
               out_valid, in_ready, alu_out);
    else pass_cnt++;
  endtask

  task automatic test_arst_mid_mul();
    int seen; int lat; logic [DATA_W-1:0] res; logic zf;
    alu_ctrl = 4'd8; alu_in_0 = 64'h1234; alu_in_1 = 64'h1234; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #3 arst = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, busy, zero_flag} !== 4'b1001 || alu_out !== '0)
      $display("FAIL arst_mid_mul: rdy/vld/busy/zf=%b%b%b%b out=%h, want 1001 out=0",
               in_ready, out_valid, busy, zero_flag, alu_out);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid || busy) seen++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL arst_no_result: active cycles=%0d, want 0", seen);
    else pass_cnt++;
    run_op(4'd8, 64'hFFFF_FFFF, 64'hFFFF_FFFF, lat, res, zf);
    total_cnt++;
    if (lat !== 65 || res !== 64'hFFFF_FFFE_0000_0001 || zf !== 1'b0)
      $display("FAIL mul_32x32: lat=%0d res=%h zf=%b, want lat=65 res=fffffffe00000001 zf=0",
               lat, res, zf);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_add_sub();
    test_slt_shift();
    test_undefined();
    test_mul();
    test_backpressure();
    test_operand_change();
    test_flush_mul();
    test_flush_idle();
    test_arst_mid_mul();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d",
             pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
